// File: rtl/serv_rf_pkg.sv
// Shared definitions for the SERV register-file RAM: geometry helpers and sequencer state encoding.
package serv_rf_pkg;

  localparam int unsigned RF_GPRS = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  // Words needed to hold 32-bit GPRs plus CSR slots at the given RF interface width.
  function automatic int unsigned rf_depth(input int unsigned width, input int unsigned csr_regs);
    return 32 * (RF_GPRS + csr_regs) / width;
  endfunction

  function automatic int unsigned rf_aw(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/serv_rf_ram_array.sv
// Simple dual-port storage: one write port, one registered read port, no control logic,
// so it can be replaced by a vendor RAM macro.
module serv_rf_ram_array #(
  parameter int unsigned dw    = 8,
  parameter int unsigned depth = 144,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_wen,
  input  logic [aw-1:0] i_waddr,
  input  logic [dw-1:0] i_wdata,
  input  logic [aw-1:0] i_raddr,
  output logic [dw-1:0] o_rdata
);

  logic [dw-1:0] r_mem [depth];
  logic [dw-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/serv_rf_ram_init.sv
// Self-initialising SERV RF RAM: clears the whole array after every reset, then serves the RF
// interface. Define SERV_RF_RAM_PARITY_EN to add a stored even-parity bit and sticky error flag.
module serv_rf_ram_init
  import serv_rf_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned csr_regs = 4,
  parameter int unsigned depth    = rf_depth(width, csr_regs)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [$clog2(depth)-1:0] i_waddr,
  input  logic [width-1:0]         i_wdata,
  input  logic                     i_wen,
  input  logic [$clog2(depth)-1:0] i_raddr,
  output logic [width-1:0]         o_rdata,
  output logic                     o_init_done,
  output logic                     o_parity_err
);

  localparam int unsigned aw = rf_aw(depth);
`ifdef SERV_RF_RAM_PARITY_EN
  localparam int unsigned dw = width + 1;
`else
  localparam int unsigned dw = width;
`endif

  rf_state_e     r_state, w_state_d;
  logic [aw-1:0] r_clr_cnt, w_clr_cnt_d;
  logic          r_rd_valid;

  logic          w_clearing;
  logic          w_last;
  logic          w_in_range;
  logic          w_wen;
  logic [aw-1:0] w_waddr;
  logic [dw-1:0] w_wdata;
  logic [dw-1:0] w_user_wdata;
  logic [dw-1:0] w_rdata;

  assign w_clearing = (r_state == RF_CLEAR);
  assign w_last     = (r_clr_cnt == aw'(depth - 1));
  assign w_in_range = ({1'b0, i_waddr} < (aw + 1)'(depth));

`ifdef SERV_RF_RAM_PARITY_EN
  assign w_user_wdata = {^i_wdata, i_wdata};
`else
  assign w_user_wdata = i_wdata;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_clr_cnt_d = r_clr_cnt;
    w_wen       = 1'b0;
    w_waddr     = i_waddr;
    w_wdata     = w_user_wdata;
    if (w_clearing) begin
      if (w_last) begin
        w_state_d = RF_RUN;
      end else begin
        w_clr_cnt_d = r_clr_cnt + aw'(1);
      end
    end
    // Clear sequencer owns the write port in CLEAR; out-of-range user writes are dropped.
    if (!i_rst) begin
      if (w_clearing) begin
        w_wen   = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
      end else begin
        w_wen = i_wen & w_in_range;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= RF_CLEAR;
      r_clr_cnt  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_clr_cnt  <= w_clr_cnt_d;
      r_rd_valid <= (r_state == RF_RUN);
    end
  end

  serv_rf_ram_array #(
    .dw    (dw),
    .depth (depth),
    .aw    (aw)
  ) u_array (
    .i_clk   (i_clk),
    .i_wen   (w_wen),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (i_raddr),
    .o_rdata (w_rdata)
  );

  // Reads are only valid when issued in RUN; otherwise the output is forced to zero.
  assign o_rdata     = r_rd_valid ? w_rdata[width-1:0] : '0;
  assign o_init_done = (r_state == RF_RUN);

`ifdef SERV_RF_RAM_PARITY_EN
  logic r_parity_err;
  logic w_par_mismatch;

  // Stored bit is even parity of the data, so a clean word XORs to zero across all dw bits.
  assign w_par_mismatch = r_rd_valid & (^w_rdata);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_parity_err <= 1'b0;
    end else if (w_par_mismatch) begin
      r_parity_err <= 1'b1;
    end
  end

  assign o_parity_err = r_parity_err | w_par_mismatch;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serv_rf_ram_init.sv
// Randomised self-checking bench for serv_rf_ram_init against a flat-array memory model.
module tb_serv_rf_ram_init;

  localparam int W   = 8;
  localparam int D   = 144;
  localparam int AW  = 8;
  localparam int D2  = 576;
  localparam int AW2 = 10;
  localparam int D32 = 36;
  localparam int AW32 = 6;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wen;
  logic [AW-1:0] i_waddr, i_raddr;
  logic [W-1:0]  i_wdata, o_rdata;
  logic          o_init_done, o_parity_err;

  logic           wen2;
  logic [AW2-1:0] waddr2, raddr2;
  logic [1:0]     wdata2, rdata2;
  logic           init2, perr2;

  logic            wen32;
  logic [AW32-1:0] waddr32, raddr32;
  logic [31:0]     wdata32, rdata32;
  logic            init32, perr32;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] model [D];

  always #5 i_clk = ~i_clk;

  serv_rf_ram_init #(.width(8), .csr_regs(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_waddr      (i_waddr),
    .i_wdata      (i_wdata),
    .i_wen        (i_wen),
    .i_raddr      (i_raddr),
    .o_rdata      (o_rdata),
    .o_init_done  (o_init_done),
    .o_parity_err (o_parity_err)
  );

  serv_rf_ram_init #(.width(2), .csr_regs(4)) dut2 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_waddr      (waddr2),
    .i_wdata      (wdata2),
    .i_wen        (wen2),
    .i_raddr      (raddr2),
    .o_rdata      (rdata2),
    .o_init_done  (init2),
    .o_parity_err (perr2)
  );

  serv_rf_ram_init #(.width(32), .csr_regs(4)) dut32 (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_waddr      (waddr32),
    .i_wdata      (wdata32),
    .i_wen        (wen32),
    .i_raddr      (raddr32),
    .o_rdata      (rdata32),
    .o_init_done  (init32),
    .o_parity_err (perr32)
  );

  function automatic logic [1:0] pat2(input int a);
    return 2'(a ^ (a >> 3) ^ 1);
  endfunction

  function automatic logic [31:0] pat32(input int a);
    return (32'(a) * 32'h0101_0101) ^ 32'hA5C3_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_zero();
    for (int a = 0; a < D; a++) model[a] = '0;
  endtask

  // One RUN cycle: read-first expectation taken from the model before the write lands.
  task automatic step(input logic wen, input int waddr, input logic [W-1:0] wdata,
                      input int raddr, input string tag);
    logic [W-1:0] exp;
    @(negedge i_clk);
    i_wen   = wen;
    i_waddr = AW'(waddr);
    i_wdata = wdata;
    i_raddr = AW'(raddr);
    exp     = model[raddr];
    @(posedge i_clk);
    #1;
    if (wen && waddr < D) model[waddr] = wdata;
    check_eq(tag, 32'(o_rdata), 32'(exp));
  endtask

  task automatic release_and_count(input string tag);
    int n;
    n = 0;
    @(negedge i_clk);
    i_rst = 1'b0;
    while (n < 1000) begin
      @(posedge i_clk);
      #1;
      n++;
      if (o_init_done) break;
    end
    check_eq(tag, 32'(n), 32'(D));
    check_eq({tag, "_rdata0"}, 32'(o_rdata), 32'h0);
    model_zero();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int wa, ra;
    i_wen = 1'b0; i_waddr = '0; i_wdata = '0; i_raddr = '0;
    wen2 = 1'b0; waddr2 = '0; wdata2 = '0; raddr2 = '0;
    wen32 = 1'b0; waddr32 = '0; wdata32 = '0; raddr32 = '0;

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_init_done", 32'(o_init_done), 32'h0);
    check_eq("rst_rdata", 32'(o_rdata), 32'h0);
    check_eq("rst_parity_err", 32'(o_parity_err), 32'h0);

    // User writes during the clear must be ignored.
    i_wen = 1'b1; i_waddr = 8'd5; i_wdata = 8'hAA;
    release_and_count("clear_len");
    step(1'b0, 0, 8'h00, 5, "clr_ignores_wen");
    check_eq("clr_ignores_wen_const", 32'(o_rdata), 32'h0);

    step(1'b1, 17, 8'h5A, 0, "wr17");
    step(1'b0, 0, 8'h00, 17, "rd17");
    check_eq("rd17_const", 32'(o_rdata), 32'h5A);

    step(1'b1, 3, 8'h11, 0, "coll_setup");
    step(1'b1, 3, 8'h22, 3, "coll_old");
    check_eq("coll_old_const", 32'(o_rdata), 32'h11);
    step(1'b0, 0, 8'h00, 3, "coll_new");
    check_eq("coll_new_const", 32'(o_rdata), 32'h22);

    repeat (300) begin
      wa = int'($urandom_range(D - 1, 0));
      ra = ($urandom_range(3, 0) == 0) ? wa : int'($urandom_range(D - 1, 0));
      step(1'($urandom), wa, W'($urandom), ra, "rand");
    end
    check_eq("rand_parity_err", 32'(o_parity_err), 32'h0);

    // Out-of-range write must not disturb any word.
    step(1'b1, 200, 8'hFF, 0, "oor_wr");
    for (int a = 0; a < D; a++) step(1'b0, 0, 8'h00, a, "oor_sweep");

    for (int a = 0; a < D; a++) step(1'b1, a, W'(a * 37 + 5), 0, "sweep_wr");
    for (int a = 0; a < D; a++) step(1'b0, 0, 8'h00, a, "sweep_rd");

`ifdef SERV_RF_RAM_PARITY_EN
    step(1'b1, 9, 8'h0F, 0, "par_wr");
    @(negedge i_clk);
    dut.u_array.r_mem[9][0] = ~dut.u_array.r_mem[9][0];
    i_wen = 1'b0;
    i_raddr = 8'd9;
    @(posedge i_clk);
    #1;
    check_eq("par_rdata", 32'(o_rdata), 32'h0E);
    check_eq("par_err_set", 32'(o_parity_err), 32'h1);
    model[9] = 8'h0E;
    step(1'b0, 0, 8'h00, 17, "par_clean_rd");
    check_eq("par_err_sticky", 32'(o_parity_err), 32'h1);
`endif

    // Reset in RUN, then abort the clear at clr_cnt=70 and check a full restart.
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("midrun_rst_init", 32'(o_init_done), 32'h0);
    check_eq("midrun_rst_rdata", 32'(o_rdata), 32'h0);
    check_eq("midrun_rst_perr", 32'(o_parity_err), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (70) @(posedge i_clk);
    #1;
    check_eq("midclr_init", 32'(o_init_done), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    release_and_count("clear_len_restart");
    for (int a = 0; a < D; a++) step(1'b0, 0, 8'h00, a, "restart_zero");

    n = 0;
    while (!(init2 && init32) && n < 2000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check_eq("w2_init", 32'(init2), 32'h1);
    check_eq("w32_init", 32'(init32), 32'h1);

    for (int a = 0; a < D2; a++) begin
      @(negedge i_clk);
      wen2 = 1'b1; waddr2 = AW2'(a); wdata2 = pat2(a);
      if (a < D32) begin
        wen32 = 1'b1; waddr32 = AW32'(a); wdata32 = pat32(a);
      end else begin
        wen32 = 1'b0;
      end
    end
    @(negedge i_clk);
    wen2 = 1'b0;
    wen32 = 1'b0;
    for (int a = 0; a < D2; a++) begin
      @(negedge i_clk);
      raddr2 = AW2'(a);
      raddr32 = AW32'(a % D32);
      @(posedge i_clk);
      #1;
      check_eq("w2_sweep", 32'(rdata2), 32'(pat2(a)));
      if (a < D32) check_eq("w32_sweep", rdata32, pat32(a));
    end
    check_eq("w2_perr", 32'(perr2), 32'h0);
    check_eq("w32_perr", 32'(perr32), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serv_rf_ram_init.md
# serv_rf_ram_init

Self-initialising register-file RAM that sits directly downstream of the SERV RF RAM interface. It consumes the interface's word-wide write port (`waddr`/`wdata`/`wen`) and read port (`raddr`), and returns `rdata` one cycle after the read address. After every reset it zeroes the whole array with an internal clear sequencer, so x0 and the CSR slots start at a known value. It then signals `o_init_done` so the core's reset release can be gated on it.

## Interface
- `width`, default 8: RAM word width; matches the RF interface width (2, 4, 8, 16, 32).
- `csr_regs`, default 4: number of CSR slots appended after the 32 GPRs.
- `depth`, default `32*(32+csr_regs)/width`: number of words.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_waddr`  in  `$clog2(depth)`  write word address.
- `i_wdata`  in  `width`  write data.
- `i_wen`  in  1  write enable.
- `i_raddr`  in  `$clog2(depth)`  read word address.
- `o_rdata`  out  `width`  registered read data.
- `o_init_done`  out  1  array cleared; normal operation.
- `o_parity_err`  out  1  sticky read-parity error flag (constant 0 without `SERV_RF_RAM_PARITY_EN`).

## Operation
- Two states:
  - CLEAR: entered on `i_rst`.
  - RUN: entered after the last clear write.
- CLEAR:
  - `clr_cnt` starts at 0.
  - Each cycle writes all-zero (and parity 0) to `mem[clr_cnt]`, then increments.
  - When `clr_cnt == depth-1`, that final write happens and the state moves to RUN.
  - `i_wen` is ignored.
  - Reads are not performed; `o_rdata` is held at 0.
- RUN:
  - If `i_wen`, then `mem[i_waddr] <= i_wdata`.
  - Every cycle, `o_rdata <= mem[i_raddr]`.
- Read/write to the same address in the same cycle is read-first: `o_rdata` returns the old word.
- Reset mid-CLEAR or mid-RUN aborts immediately. The next cycle is CLEAR with `clr_cnt = 0`, and the array contents are rewritten from scratch.
- `clr_cnt` width is `$clog2(depth)`. It never wraps, because the state leaves CLEAR at `depth-1`.
- `i_waddr` and `i_raddr` values ≥ `depth` are illegal and produce undefined data. They must not corrupt other words; writes to such addresses are dropped.

## Timing
- Reset values, in the cycle after `i_rst` is high:
  - `o_init_done = 0`
  - `o_rdata = 0`
  - `o_parity_err = 0`
  - state = CLEAR
  - `clr_cnt = 0`
- Clear duration is exactly `depth` cycles after `i_rst` falls (144 for the defaults). `o_init_done` rises in the cycle after the `depth-1` write and stays high until the next `i_rst`.
- Read latency is 1: an address presented in cycle N gives data on `o_rdata` in cycle N+1. This matches the RF interface's sampling of `i_rdata` one cycle after `o_raddr`.
- A write issued in cycle N is visible to a read issued in cycle N+1 or later.
- The first RUN cycle accepts writes and reads. `o_rdata` in that cycle is still 0, because no read was performed in the last CLEAR cycle.

## Configuration
- `SERV_RF_RAM_PARITY_EN` defined:
  - The array is `width+1` bits wide; bit `width` stores the even parity `^i_wdata` on write.
  - CLEAR writes parity 0.
  - The read path registers the stored parity bit alongside `o_rdata`.
  - In the cycle `o_rdata` is presented in RUN, a recomputed parity mismatch sets `o_parity_err`. The flag stays set until `i_rst`.
  - No correction is performed and `o_rdata` is not altered.
- Not defined:
  - Array is `width` bits.
  - `o_parity_err` is tied to 0.
  - No extra flops.

## Structure
- Shared package `serv_rf_pkg`:
  - depth/address-width computation from `width` and `csr_regs`.
  - `RF_GPRS = 32`.
  - state encoding constants `RF_CLEAR` and `RF_RUN`.
- One sub-module, `serv_rf_ram_array`: the simple dual-port storage (one write port, one registered read port, parameterised data width). It contains no control, so it can be swapped for an FPGA/ASIC macro.
- The top level holds the clear sequencer, the write mux (clear vs. user), and the parity logic.

## Test plan
- Reset release, width=8/csr_regs=4:
  - `o_init_done` is 0 for 144 cycles and goes to 1 in cycle 145.
  - During the clear, drive `i_wen=1`, `i_waddr=5`, `i_wdata=0xAA`; a later read of addr 5 returns 0x00.
- RUN write/read:
  - Write 0x5A to addr 17 in cycle N.
  - Read addr 17 in cycle N+1; `o_rdata=0x5A` in cycle N+2.
- Same-address collision:
  - addr 3 holds 0x11; write 0x22 and read addr 3 in the same cycle.
  - `o_rdata=0x11` next cycle; the following read returns 0x22.
- Reset mid-CLEAR:
  - Assert `i_rst` at `clr_cnt=70`.
  - Clear restarts; `o_init_done` rises exactly 144 cycles after the second release; words 0–143 all read 0.
- Full sweep, width=2 and width=32:
  - Write address-derived patterns to all `depth` words, then read them back; all match.
  - Last word (`depth-1`) is reachable.
- `SERV_RF_RAM_PARITY_EN`:
  - Write 0x0F to addr 9, then hierarchically flip bit 0 of the stored word and read addr 9.
  - `o_rdata=0x0E` and `o_parity_err=1` in the same cycle; the flag stays 1 after reading clean words and clears only on `i_rst`.
